// File: rtl/sdram_port_arbiter.sv
// Shares one 64-bit Avalon-MM SDRAM port between display scanout (M0, high prio) and rasterizer (M1).
// Latency: command path 0 cycles while owned, 1 cycle IDLE->grant; read-return routing 0 cycles.
// Backpressure: slave waitrequest goes to the owner; reads also stall while the pending-read FIFO is full.
module sdram_port_arbiter #(
    parameter int MAX_PENDING = 4,
    parameter int MAX_HOLD    = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [28:0] m0_address,
    input  logic [7:0]  m0_burstcount,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [63:0] m0_writedata,
    input  logic [7:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [63:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic [28:0] m1_address,
    input  logic [7:0]  m1_burstcount,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [63:0] m1_writedata,
    input  logic [7:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [63:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic [28:0] s_address,
    output logic [7:0]  s_burstcount,
    output logic        s_read,
    output logic        s_write,
    output logic [63:0] s_writedata,
    output logic [7:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [63:0] s_readdata,
    input  logic        s_readdatavalid,
    output logic [1:0]  grant,
    output logic        err_orphan
);

    localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [PW:0]   FIFO_DEPTH = (PW+1)'(MAX_PENDING);

    // State encoding doubles as the debug grant value.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    // One outstanding read command: who issued it and how many beats remain.
    typedef struct packed {
        logic       owner;
        logic [7:0] beats;
    } pend_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt;
    pend_t         fifo_mem [MAX_PENDING];
    pend_t         head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          fifo_full, fifo_empty;
    logic          req0, req1, blk0, blk1;
    logic          acc, push, pop_beat, pop;
    logic [7:0]    push_beats;

    assign req0       = m0_read | m0_write;
    assign req1       = m1_read | m1_write;
    assign fifo_full  = (count == FIFO_DEPTH);
    assign fifo_empty = (count == '0);
    assign blk0       = m0_read & fifo_full;
    assign blk1       = m1_read & fifo_full;
    assign grant      = state;

    // Command mux: owner's command goes to the slave; everything idle and stalled otherwise.
    always_comb begin
        s_address      = '0;
        s_burstcount   = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state)
            OWN0: begin
                s_address      = m0_address;
                s_burstcount   = m0_burstcount;
                s_read         = m0_read & ~blk0;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest | blk0;
            end
            OWN1: begin
                s_address      = m1_address;
                s_burstcount   = m1_burstcount;
                s_read         = m1_read & ~blk1;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest | blk1;
            end
            default: ;
        endcase
    end

    assign acc = (s_read | s_write) & ~s_waitrequest;

    // Grant changes only between commands; M0 preempts M1, M1 is let in after MAX_HOLD M0 commands.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0)      state_nxt = OWN0;
                else if (req1) state_nxt = OWN1;
            end
            OWN0: begin
                if (!req0)                                   state_nxt = req1 ? OWN1 : IDLE;
                else if (acc && req1 && hold_cnt == HOLD_LAST) state_nxt = OWN1;
            end
            OWN1: begin
                if (!req1)             state_nxt = req0 ? OWN0 : IDLE;
                else if (acc && req0)  state_nxt = OWN0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Counts M0 commands accepted while M1 is waiting; restarts whenever M1 stops waiting or M0 loses the port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (state == OWN0 && state_nxt == OWN0 && req1) begin
            if (acc) hold_cnt <= hold_cnt + 1'b1;
        end else begin
            hold_cnt <= '0;
        end
    end

    // Read tracking: head entry owns every returning beat until its beat count runs out.
    assign push       = acc & s_read;
    assign push_beats = (s_burstcount == 8'd0) ? 8'd1 : s_burstcount;
    assign head       = fifo_mem[rd_ptr];
    assign pop_beat   = s_readdatavalid & ~fifo_empty;
    assign pop        = pop_beat & (head.beats == 8'd1);

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop_beat & ~head.owner;
    assign m1_readdatavalid = pop_beat & head.owner;

    // Entry storage; validity is tracked by the pointers, so no reset is needed here.
    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= '{owner: (state == OWN1), beats: push_beats};
        if (pop_beat && !pop)
            fifo_mem[rd_ptr].beats <= head.beats - 8'd1;
    end

    // FIFO pointers, occupancy and the sticky orphan-beat flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (s_readdatavalid && fifo_empty) err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [28:0] m0_address, m1_address, s_address;
    logic [7:0]  m0_burstcount, m1_burstcount, s_burstcount;
    logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
    logic [63:0] m0_writedata, m1_writedata, s_writedata;
    logic [7:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic [63:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid, s_readdatavalid;
    logic [1:0]  grant;
    logic        err_orphan;

    sdram_port_arbiter #(.MAX_PENDING(4), .MAX_HOLD(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .grant(grant), .err_orphan(err_orphan)
    );

    always #5 clock = ~clock;

    typedef struct { logic [1:0] gnt; logic rd; logic [28:0] addr; logic [7:0] bc; logic [63:0] wd; logic [7:0] be; } cmd_t;
    typedef struct { logic owner; int beats; } pend_t;
    typedef struct { logic [1:0] vld; logic [63:0] data; } ret_t;
    typedef struct { logic has_owner; logic owner; } inj_t;

    cmd_t  cmd_exp[$];
    pend_t pend_q[$];
    ret_t  ret_exp[$];
    inj_t  inj_q[$];
    int    acc_cyc[$];
    bit    resp_en = 1'b0;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    data_n = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_cmd(input logic [1:0] gnt, input logic rd, input logic [28:0] a,
                           input logic [7:0] bc, input logic [63:0] d);
        cmd_t e;
        e.gnt = gnt; e.rd = rd; e.addr = a; e.bc = bc; e.wd = d;
        e.be = (gnt == 2'b01) ? 8'hFF : 8'h0F;
        cmd_exp.push_back(e);
    endtask

    task automatic inject(input logic has_owner, input logic owner);
        inj_t i;
        i.has_owner = has_owner; i.owner = owner;
        inj_q.push_back(i);
    endtask

    // Master driver: present a command and hold it until accepted (bounded).
    task automatic issue(input int m, input bit rd, input logic [28:0] a, input logic [7:0] bc, input logic [63:0] d);
        bit done = 1'b0;
        if (m == 0) begin
            m0_address = a; m0_burstcount = bc; m0_read = rd; m0_write = !rd; m0_writedata = d; m0_byteenable = 8'hFF;
        end else begin
            m1_address = a; m1_burstcount = bc; m1_read = rd; m1_write = !rd; m1_writedata = d; m1_byteenable = 8'h0F;
        end
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clock);
            done = (m == 0) ? !m0_waitrequest : !m1_waitrequest;
            @(posedge clock); #1;
        end
        if (m == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
        else        begin m1_read = 1'b0; m1_write = 1'b0; end
        if (!done) begin
            total++; bad++;
            $display("FAIL issue_timeout: master %0d addr %0h got no accept expected accept", m, a);
        end
    endtask

    // Wait for all outstanding returns to drain, then confirm every expectation was consumed.
    task automatic end_test(input string tag);
        for (int c = 0; c < 200 && (pend_q.size() + inj_q.size() + ret_exp.size()) != 0; c++)
            @(posedge clock);
        repeat (2) @(posedge clock);
        #1;
        check({tag, "_cmd_left"}, 64'(cmd_exp.size()), 64'd0);
        check({tag, "_ret_left"}, 64'(ret_exp.size()), 64'd0);
    endtask

    // Command monitor: every slave-accepted command is compared with the next expected one.
    always @(negedge clock) begin : cmd_mon
        cmd_t e;
        pend_t p;
        if (reset_n && (s_read || s_write) && !s_waitrequest) begin
            acc_cyc.push_back(cyc);
            if (cmd_exp.size() == 0) begin
                total++; bad++;
                $display("FAIL cmd_unexpected: got addr %0h expected none", s_address);
            end else begin
                e = cmd_exp.pop_front();
                check("cmd_grant", 64'(grant), 64'(e.gnt));
                check("cmd_rdwr", 64'({s_read, s_write}), 64'({e.rd, !e.rd}));
                check("cmd_addr", 64'(s_address), 64'(e.addr));
                check("cmd_burst", 64'(s_burstcount), 64'(e.bc));
                check("cmd_be", 64'(s_byteenable), 64'(e.be));
                if (!e.rd) check("cmd_wdata", s_writedata, e.wd);
                if (e.rd && resp_en) begin
                    p.owner = (e.gnt == 2'b10);
                    p.beats = (e.bc == 8'd0) ? 1 : int'(e.bc);
                    pend_q.push_back(p);
                end
            end
        end
    end

    // Return monitor: every routed beat is compared with the next expected owner/data.
    always @(negedge clock) begin : ret_mon
        ret_t r;
        if (reset_n && (m0_readdatavalid || m1_readdatavalid)) begin
            if (ret_exp.size() == 0) begin
                total++; bad++;
                $display("FAIL ret_unexpected: got vld %b expected none", {m1_readdatavalid, m0_readdatavalid});
            end else begin
                r = ret_exp.pop_front();
                check("ret_vld", 64'({m1_readdatavalid, m0_readdatavalid}), 64'(r.vld));
                check("ret_data0", m0_readdata, r.data);
                check("ret_data1", m1_readdata, r.data);
            end
        end
    end

    // Slave responder: auto-returns expected reads one cycle later, or plays injected beats.
    initial begin : responder
        pend_t p;
        inj_t  i;
        ret_t  r;
        s_readdatavalid = 1'b0;
        s_readdata      = '0;
        forever begin
            @(posedge clock); #1;
            s_readdatavalid = 1'b0;
            if (resp_en && pend_q.size() > 0) begin
                p = pend_q.pop_front();
                data_n++;
                s_readdata = {32'hD00D_0000, 32'(data_n)};
                s_readdatavalid = 1'b1;
                r.vld = p.owner ? 2'b10 : 2'b01; r.data = s_readdata;
                ret_exp.push_back(r);
                p.beats--;
                if (p.beats > 0) pend_q.push_front(p);
            end else if (!resp_en && inj_q.size() > 0) begin
                i = inj_q.pop_front();
                data_n++;
                s_readdata = {32'hBEEF_0000, 32'(data_n)};
                s_readdatavalid = 1'b1;
                if (i.has_owner) begin
                    r.vld = i.owner ? 2'b10 : 2'b01; r.data = s_readdata;
                    ret_exp.push_back(r);
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0;
        bit saw_vld;
        reset_n = 1'b0;
        m0_address = '0; m0_burstcount = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_burstcount = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_s_rdwr", 64'({s_read, s_write}), 64'd0);
        check("rst_wait", 64'({m1_waitrequest, m0_waitrequest}), 64'b11);
        check("rst_rdv", 64'({m1_readdatavalid, m0_readdatavalid}), 64'd0);
        check("rst_err", 64'(err_orphan), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // 1: M1 writes 4 words, M0 idle.
        resp_en = 1'b1;
        for (int i = 0; i < 4; i++) exp_cmd(2'b10, 1'b0, 29'h0ABC000 + 29'(i), 8'd1, 64'h1111_0000_0000_0000 + 64'(i));
        acc_cyc.delete();
        t0 = cyc;
        check("t1_grant_idle", 64'(grant), 64'd0);
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 29'h0ABC000 + 29'(i), 8'd1, 64'h1111_0000_0000_0000 + 64'(i));
        check("t1_acc_count", 64'(acc_cyc.size()), 64'd4);
        check("t1_grant_latency", 64'((acc_cyc.size() > 0) ? acc_cyc[0] - t0 : -1), 64'd1);
        check("t1_back_to_back", 64'((acc_cyc.size() > 3) ? acc_cyc[3] - acc_cyc[0] : -1), 64'd3);
        end_test("t1");
        check("t1_grant_end", 64'(grant), 64'd0);

        // 2: M1 streams writes, M0 raises a read on M1's 4th write.
        for (int i = 0; i < 4; i++) exp_cmd(2'b10, 1'b0, 29'h200 + 29'(i), 8'd1, 64'h2222_0000 + 64'(i));
        for (int i = 0; i < 3; i++) exp_cmd(2'b01, 1'b1, 29'h300 + 29'(i), 8'd1, 64'd0);
        for (int i = 4; i < 6; i++) exp_cmd(2'b10, 1'b0, 29'h200 + 29'(i), 8'd1, 64'h2222_0000 + 64'(i));
        fork
            for (int i = 0; i < 6; i++) issue(1, 1'b0, 29'h200 + 29'(i), 8'd1, 64'h2222_0000 + 64'(i));
            begin
                repeat (4) @(posedge clock);
                #1;
                for (int i = 0; i < 3; i++) issue(0, 1'b1, 29'h300 + 29'(i), 8'd1, 64'd0);
            end
        join
        end_test("t2");

        // 3: M0 reads back-to-back, M1 waits: exactly 16 M0 reads, one M1 command, then M0 again.
        for (int i = 0; i < 16; i++) exp_cmd(2'b01, 1'b1, 29'h400 + 29'(i), 8'd1, 64'd0);
        exp_cmd(2'b10, 1'b0, 29'h500, 8'd1, 64'h3333);
        for (int i = 16; i < 20; i++) exp_cmd(2'b01, 1'b1, 29'h400 + 29'(i), 8'd1, 64'd0);
        fork
            for (int i = 0; i < 20; i++) issue(0, 1'b1, 29'h400 + 29'(i), 8'd1, 64'd0);
            issue(1, 1'b0, 29'h500, 8'd1, 64'h3333);
        join
        end_test("t3");

        // 4: M0 4-beat burst then M1 read with burstcount 0 (one beat); 5 beats return.
        resp_en = 1'b0;
        exp_cmd(2'b01, 1'b1, 29'h600, 8'd4, 64'd0);
        exp_cmd(2'b10, 1'b1, 29'h700, 8'd0, 64'd0);
        issue(0, 1'b1, 29'h600, 8'd4, 64'd0);
        issue(1, 1'b1, 29'h700, 8'd0, 64'd0);
        for (int i = 0; i < 4; i++) inject(1'b1, 1'b0);
        inject(1'b1, 1'b1);
        end_test("t4");
        check("t4_no_orphan", 64'(err_orphan), 64'd0);

        // 5: no returns; 4 reads fill the tracker, the 5th stalls until one beat comes back.
        for (int i = 0; i < 5; i++) exp_cmd(2'b10, 1'b1, 29'h800 + 29'(i), 8'd1, 64'd0);
        acc_cyc.delete();
        fork
            for (int i = 0; i < 5; i++) issue(1, 1'b1, 29'h800 + 29'(i), 8'd1, 64'd0);
            begin
                for (int c = 0; c < 100 && acc_cyc.size() < 4; c++) @(posedge clock);
                repeat (3) @(posedge clock);
                @(negedge clock);
                check("t5_acc_before", 64'(acc_cyc.size()), 64'd4);
                check("t5_wait", 64'(m1_waitrequest), 64'd1);
                check("t5_s_read", 64'(s_read), 64'd0);
                check("t5_grant", 64'(grant), 64'b10);
                inject(1'b1, 1'b1);
            end
        join
        check("t5_acc_after", 64'(acc_cyc.size()), 64'd5);
        end_test("t5");
        check("t5_no_orphan", 64'(err_orphan), 64'd0);
        reset_n = 1'b0;
        @(negedge clock);
        check("t5_rst_grant", 64'(grant), 64'd0);
        check("t5_rst_wait", 64'({m1_waitrequest, s_read}), 64'b10);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // 6: orphan beat with nothing pending.
        inject(1'b0, 1'b0);
        saw_vld = 1'b0;
        repeat (3) begin
            @(negedge clock);
            saw_vld = saw_vld | m0_readdatavalid | m1_readdatavalid;
        end
        check("t6_no_rdv", 64'(saw_vld), 64'd0);
        check("t6_err_set", 64'(err_orphan), 64'd1);
        repeat (5) @(posedge clock);
        #1;
        check("t6_err_sticky", 64'(err_orphan), 64'd1);
        reset_n = 1'b0;
        @(negedge clock);
        check("t6_err_rst", 64'(err_orphan), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // 7: slave stall holds off the owner until released.
        s_waitrequest = 1'b1;
        exp_cmd(2'b01, 1'b0, 29'h900, 8'd1, 64'h4444);
        fork
            issue(0, 1'b0, 29'h900, 8'd1, 64'h4444);
            begin
                repeat (3) @(posedge clock);
                @(negedge clock);
                check("t7_stall_wait", 64'({m0_waitrequest, s_write}), 64'b11);
                check("t7_stall_grant", 64'(grant), 64'b01);
                @(posedge clock); #1;
                s_waitrequest = 1'b0;
            end
        join
        end_test("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
